// File: rtl/sram_bist_ctrl.sv
// sram_bist_ctrl: March C- built-in self test controller for a gf180mcu x8 SRAM macro.
//
// Runs the six-element March C- sequence over all 2**ADDR_W words and reports the
// first mismatch. Every output, including the SRAM command bus, is registered.
//
// Ports
//   clk        rising-edge clock, shared with the SRAM macro CLK
//   rst        asynchronous active-high reset
//   start      single-cycle run request (ignored while busy)
//   busy       high while a test is running
//   done       high from test end until the next accepted start
//   pass       valid while done; 1 = no mismatch
//   fail_addr  address of the first mismatch
//   fail_elem  march element (0-5) of the first mismatch
//   fail_data  sram_q XOR expected at the first mismatch
//   sram_cen   macro CEN (active low)
//   sram_gwen  macro GWEN (active-low global write)
//   sram_wen   macro WEN (active-low bit write enables)
//   sram_a     macro address
//   sram_d     macro write data
//   sram_q     macro read data
module sram_bist_ctrl #(
    parameter int unsigned ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [2:0]        fail_elem,
    output logic [7:0]        fail_data,
    output logic              sram_cen,
    output logic              sram_gwen,
    output logic [7:0]        sram_wen,
    output logic [ADDR_W-1:0] sram_a,
    output logic [7:0]        sram_d,
    input  logic [7:0]        sram_q
);

    localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

    // StRw presents a write while comparing the previous read; StRc compares only.
    typedef enum logic [2:0] {StIdle, StWr, StRd, StRw, StRc, StDone} state_e;

    state_e            state_q;
    logic [2:0]        elem_q;
    logic [ADDR_W-1:0] addr_q;
    logic              fail_seen_q;

    // Elements 3..5 walk the address space downwards.
    function automatic logic elem_down(input logic [2:0] e);
        return e >= 3'd3;
    endfunction

    // r1 in M2/M4, r0 elsewhere.
    function automatic logic [7:0] read_exp(input logic [2:0] e);
        return (e == 3'd2 || e == 3'd4) ? 8'hFF : 8'h00;
    endfunction

    // w1 in M1/M3, w0 elsewhere.
    function automatic logic [7:0] write_data(input logic [2:0] e);
        return (e == 3'd1 || e == 3'd3) ? 8'hFF : 8'h00;
    endfunction

    logic              addr_is_last;
    logic [ADDR_W-1:0] addr_step;
    logic [2:0]        elem_next;
    logic [ADDR_W-1:0] addr_reload;
    logic [7:0]        exp_data;
    logic              mismatch;

    always_comb begin
        addr_is_last = elem_down(elem_q) ? (addr_q == '0) : (addr_q == ADDR_LAST);
        addr_step    = elem_down(elem_q) ? addr_q - 1'b1 : addr_q + 1'b1;
        elem_next    = elem_q + 3'd1;
        addr_reload  = elem_down(elem_next) ? ADDR_LAST : '0;
        exp_data     = read_exp(elem_q);
        mismatch     = (sram_q != exp_data);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            elem_q      <= 3'd0;
            addr_q      <= '0;
            fail_seen_q <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            pass        <= 1'b0;
            fail_addr   <= '0;
            fail_elem   <= 3'd0;
            fail_data   <= 8'h00;
            sram_cen    <= 1'b1;
            sram_gwen   <= 1'b1;
            sram_wen    <= 8'hFF;
            sram_a      <= '0;
            sram_d      <= 8'h00;
        end else begin
            // Idle command unless a state below issues an access.
            sram_cen  <= 1'b1;
            sram_gwen <= 1'b1;
            sram_wen  <= 8'hFF;
            sram_a    <= '0;
            sram_d    <= 8'h00;

            unique case (state_q)
                StIdle, StDone: begin
                    if (state_q == StDone && busy) begin
                        // One settling cycle after the last compare before publishing.
                        busy <= 1'b0;
                        done <= 1'b1;
                        pass <= ~fail_seen_q;
                    end else if (start) begin
                        busy        <= 1'b1;
                        done        <= 1'b0;
                        pass        <= 1'b0;
                        fail_addr   <= '0;
                        fail_elem   <= 3'd0;
                        fail_data   <= 8'h00;
                        fail_seen_q <= 1'b0;
                        elem_q      <= 3'd0;
                        addr_q      <= '0;
                        state_q     <= StWr;
                        sram_cen    <= 1'b0;
                        sram_gwen   <= 1'b0;
                        sram_wen    <= 8'h00;
                        sram_a      <= '0;
                        sram_d      <= 8'h00;
                    end
                end

                StWr: begin
                    if (addr_q == ADDR_LAST) begin
                        elem_q    <= 3'd1;
                        addr_q    <= '0;
                        state_q   <= StRd;
                        sram_cen  <= 1'b0;
                        sram_a    <= '0;
                    end else begin
                        addr_q    <= addr_q + 1'b1;
                        sram_cen  <= 1'b0;
                        sram_gwen <= 1'b0;
                        sram_wen  <= 8'h00;
                        sram_a    <= addr_q + 1'b1;
                        sram_d    <= 8'h00;
                    end
                end

                StRd: begin
                    if (elem_q == 3'd5) begin
                        state_q <= StRc;
                    end else begin
                        state_q   <= StRw;
                        sram_cen  <= 1'b0;
                        sram_gwen <= 1'b0;
                        sram_wen  <= 8'h00;
                        sram_a    <= addr_q;
                        sram_d    <= write_data(elem_q);
                    end
                end

                StRw, StRc: begin
                    if (mismatch) begin
                        fail_addr   <= addr_q;
                        fail_elem   <= elem_q;
                        fail_data   <= sram_q ^ exp_data;
                        fail_seen_q <= 1'b1;
                        pass        <= 1'b0;
                        state_q     <= StDone;
                    end else if (addr_is_last) begin
                        if (state_q == StRc) begin
                            state_q <= StDone;
                        end else begin
                            elem_q   <= elem_next;
                            addr_q   <= addr_reload;
                            state_q  <= StRd;
                            sram_cen <= 1'b0;
                            sram_a   <= addr_reload;
                        end
                    end else begin
                        addr_q   <= addr_step;
                        state_q  <= StRd;
                        sram_cen <= 1'b0;
                        sram_a   <= addr_step;
                    end
                end

                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
